// File: rtl/seq_pkg.sv
// Shared encodings for the multicycle sequencer and the main control decoder:
// FSM states, RV64 base opcodes, opcode classes and error codes.
package seq_pkg;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StIf   = 3'd1,
        StId   = 3'd2,
        StExe  = 3'd3,
        StMem  = 3'd4,
        StWb   = 3'd5,
        StHalt = 3'd6
    } state_e;

    localparam logic [6:0] OpR  = 7'b0110011;
    localparam logic [6:0] OpI  = 7'b0010011;
    localparam logic [6:0] OpLd = 7'b0000011;
    localparam logic [6:0] OpSt = 7'b0100011;
    localparam logic [6:0] OpBr = 7'b1100011;

    typedef enum logic [2:0] {
        ClsR,
        ClsI,
        ClsLd,
        ClsSt,
        ClsBr,
        ClsIll
    } op_class_e;

    localparam logic [1:0] ErrNone    = 2'd0;
    localparam logic [1:0] ErrIllegal = 2'd1;
    localparam logic [1:0] ErrTimeout = 2'd2;

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Sequencer <-> datapath bundle: run control and status flags in, per-stage strobes and
// status out. master is the sequencer side, slave is the datapath side.
interface multicycle_sequencer_if #(
    parameter int unsigned CNT_WIDTH = 32
);
    logic                 enable;
    logic [6:0]           opcode;
    logic                 zero;
    logic                 mem_ready;
    logic [2:0]           state;
    logic                 ir_write;
    logic                 pc_write;
    logic                 pc_src;
    logic                 alu_buf_en;
    logic                 mem_read;
    logic                 mem_write;
    logic                 reg_write;
    logic                 instr_done;
    logic [CNT_WIDTH-1:0] retired;
    logic                 halted;
    logic [1:0]           err_code;

    modport master (
        input  enable, opcode, zero, mem_ready,
        output state, ir_write, pc_write, pc_src, alu_buf_en, mem_read, mem_write,
               reg_write, instr_done, retired, halted, err_code
    );

    modport slave (
        output enable, opcode, zero, mem_ready,
        input  state, ir_write, pc_write, pc_src, alu_buf_en, mem_read, mem_write,
               reg_write, instr_done, retired, halted, err_code
    );

endinterface

// File: rtl/opcode_classifier.sv
// Combinational opcode -> instruction class decode, shared with the main control decoder.
module opcode_classifier
    import seq_pkg::*;
(
    input  logic [6:0] opcode_i,
    output op_class_e  op_class_o
);

    always_comb begin
        op_class_o = ClsIll;
        case (opcode_i)
            OpR:     op_class_o = ClsR;
            OpI:     op_class_o = ClsI;
            OpLd:    op_class_o = ClsLd;
            OpSt:    op_class_o = ClsSt;
            OpBr:    op_class_o = ClsBr;
            default: op_class_o = ClsIll;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle control FSM for the RV64 datapath: owns every write strobe, sequences
// IF/ID/EXE/MEM/WB, waits on mem_ready with a timeout, halts on errors, counts retirements.
module multicycle_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input logic                    clk,
    input logic                    reset,
    multicycle_sequencer_if.master bus
);

    localparam logic [7:0] TimeoutLimit = 8'(MEM_TIMEOUT);

    state_e               state_q, state_d, boundary;
    op_class_e            cls_q, cls_d, id_class;
    logic [1:0]           err_q, err_d;
    logic [7:0]           tmo_q, tmo_d;
    logic [CNT_WIDTH-1:0] retired_q;

    logic ir_write, pc_write, pc_src, alu_buf_en;
    logic mem_read, mem_write, reg_write, instr_done;

    opcode_classifier u_classifier (
        .opcode_i   (bus.opcode),
        .op_class_o (id_class)
    );

    // Instruction boundary: enable is only honoured between instructions.
    assign boundary = bus.enable ? StIf : StIdle;

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        case (state_q)
            StIdle: if (bus.enable) state_d = StIf;
            StIf:   state_d = StId;
            StId: begin
                cls_d = id_class;
                if (id_class == ClsIll) begin
                    state_d = StHalt;
                    err_d   = ErrIllegal;
                end else begin
                    state_d = StExe;
                end
            end
            StExe: begin
                case (cls_q)
                    ClsBr:        state_d = boundary;
                    ClsR, ClsI:   state_d = StWb;
                    ClsLd, ClsSt: begin
                        state_d = StMem;
                        tmo_d   = '0;
                    end
                    default:      state_d = StHalt;
                endcase
            end
            StMem: begin
                if (bus.mem_ready) begin
                    state_d = (cls_q == ClsSt) ? boundary : StWb;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                    if (tmo_d == TimeoutLimit) begin
                        state_d = StHalt;
                        err_d   = ErrTimeout;
                    end
                end
            end
            StWb:    state_d = boundary;
            StHalt:  state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_buf_en = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        instr_done = 1'b0;
        case (state_q)
            StIf: ir_write = 1'b1;
            StExe: begin
                alu_buf_en = 1'b1;
                if (cls_q == ClsBr) begin
                    pc_write   = 1'b1;
                    pc_src     = bus.zero;
                    instr_done = 1'b1;
                end
            end
            StMem: begin
                mem_read  = (cls_q == ClsLd);
                mem_write = (cls_q == ClsSt);
                // A store retires in MEM on the completing cycle; a load still needs WB.
                if (bus.mem_ready && cls_q == ClsSt) begin
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                end
            end
            StWb: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cls_q     <= ClsIll;
            err_q     <= ErrNone;
            tmo_q     <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            if (instr_done) retired_q <= retired_q + CNT_WIDTH'(1);
        end
    end

    assign bus.state      = state_q;
    assign bus.ir_write   = ir_write;
    assign bus.pc_write   = pc_write;
    assign bus.pc_src     = pc_src;
    assign bus.alu_buf_en = alu_buf_en;
    assign bus.mem_read   = mem_read;
    assign bus.mem_write  = mem_write;
    assign bus.reg_write  = reg_write;
    assign bus.instr_done = instr_done;
    assign bus.retired    = retired_q;
    assign bus.halted     = (state_q == StHalt);
    assign bus.err_code   = err_q;

endmodule
